// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
// Only the defaults live here; the arbiter takes its widths as parameters.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the grant is combinational from req and the rotating pointer.
// The pointer moves just past the winner whenever a grant is issued and advance is set.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rrPtr_q, rrPtr_d;
  logic          found;

  // Scan starts at the pointer and wraps; the first requester found wins.
  always_comb begin
    gnt     = '0;
    rrPtr_d = rrPtr_q;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(rrPtr_q) + k) % N))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
          if (advance) begin
            rrPtr_d = PW'((i + 1) % N);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ producers.
// Each producer has a one-entry holding buffer; writes to the zero register are dropped.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic                             rf_write_en,
  output logic [ADDR_W-1:0]                rf_write_reg,
  output logic [DATA_W-1:0]                rf_write_data,
  output logic [NUM_REQ-1:0]               grant,
  output logic [(2**ADDR_W)-1:0]           pending_mask
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0]             holdV_q;
  logic [NUM_REQ-1:0][ADDR_W-1:0] holdAddr_q;
  logic [NUM_REQ-1:0][DATA_W-1:0] holdData_q;
  logic [NUM_REQ-1:0]             arbReq;
  logic [NUM_REQ-1:0]             accept;

  // Reset masks the arbiter so no stale buffer can strobe while reset is high.
  assign arbReq = reset ? '0 : holdV_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arbReq),
    .advance (!reset),
    .gnt     (grant)
  );

  assign req_ready = reset ? '0 : (~holdV_q | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        holdV_q[i]    <= 1'b0;
        holdAddr_q[i] <= '0;
        holdData_q[i] <= '0;
      end else if (accept[i] && (req_addr[i] != ADDR_W'(ZERO_REG))) begin
        holdV_q[i]    <= 1'b1;
        holdAddr_q[i] <= req_addr[i];
        holdData_q[i] <= req_data[i];
      end else if (grant[i]) begin
        holdV_q[i]    <= 1'b0;
      end
    end
  end

  // Grant is one-hot, so OR-ing the gated buffers acts as the output mux.
  always_comb begin
    rf_write_en   = |grant;
    rf_write_reg  = '0;
    rf_write_data = '0;
    pending_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rf_write_reg  = rf_write_reg  | holdAddr_q[i];
        rf_write_data = rf_write_data | holdData_q[i];
      end
      if (holdV_q[i] && !reset) begin
        pending_mask[holdAddr_q[i]] = 1'b1;
      end
    end
  end

endmodule
